// File: rtl/systolic_ctrl.sv
// Feeder/sequencer for a 4x4 output-stationary systolic multiply array.
// Buffers A and B, then streams them skewed onto the array edges and flags completion.
module systolic_ctrl #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [3:0]      wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            pe_clear,
  output logic [4*DW-1:0] a_edge,
  output logic [4*DW-1:0] b_edge
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      t, t_nxt;
  logic [DW-1:0]   buf_a [16];
  logic [DW-1:0]   buf_b [16];
  logic            busy_nxt, done_nxt, clear_nxt;
  logic [4*DW-1:0] a_nxt, b_nxt;
  logic [3:0]      da, db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        buf_a[i] <= '0;
        buf_b[i] <= '0;
      end
    end else if (wr_en && !busy) begin
      if (wr_sel) buf_b[wr_addr] <= wr_data;
      else        buf_a[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    case (state)
      IDLE: begin
        t_nxt = '0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        state_nxt = FEED;
        t_nxt     = '0;
      end
      FEED: begin
        t_nxt = t + 4'd1;
        if (t == 4'd6) state_nxt = DRAIN;
      end
      DRAIN: begin
        t_nxt = t + 4'd1;
        if (t == 4'd9) begin
          state_nxt = DONE;
          t_nxt     = '0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
      default: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state/step so the registered copies line up with the state they describe.
  // An index below zero wraps to 13..15, so the upper bits being clear is the whole in-range test.
  always_comb begin
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state_nxt == DONE);
    clear_nxt = (state_nxt == CLEAR);
    a_nxt     = '0;
    b_nxt     = '0;
    da        = '0;
    db        = '0;
    if (state_nxt == FEED) begin
      for (int i = 0; i < 4; i++) begin
        da = t_nxt - 4'(i);
        if (da[3:2] == 2'b00) a_nxt[i*DW +: DW] = buf_a[{2'(i), da[1:0]}];
        db = t_nxt - 4'(i);
        if (db[3:2] == 2'b00) b_nxt[i*DW +: DW] = buf_b[{db[1:0], 2'(i)}];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      pe_clear <= 1'b0;
      a_edge   <= '0;
      b_edge   <= '0;
    end else begin
      busy     <= busy_nxt;
      done     <= done_nxt;
      pe_clear <= clear_nxt;
      a_edge   <= a_nxt;
      b_edge   <= b_nxt;
    end
  end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8: signed operand width; array dimension fixed at N=4.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wr_en  input  1  operand-buffer write strobe.
REQ-005 SHALL have port wr_sel  input  1  write target: 0 = A buffer, 1 = B buffer.
REQ-006 SHALL have port wr_addr  input  4  element index, row*4+col.
REQ-007 SHALL have port wr_data  input  DW  signed operand value.
REQ-008 SHALL have port start  input  1  request one 4x4 multiply C=A*B.
REQ-009 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse; array accumulators hold final C.
REQ-011 SHALL have port pe_clear  output  1  drives the clear input of all 16 PEs.
REQ-012 SHALL have port a_edge  output  4*DW  left-edge operands; slice i feeds array row i.
REQ-013 SHALL have port b_edge  output  4*DW  top-edge operands; slice j feeds array column j.

Function
REQ-014 SHALL hold two 16-entry DW-bit buffers, A and B, written when wr_en=1 and busy=0.
REQ-015 SHALL ignore wr_en while busy=1; buffer contents SHALL NOT change mid-operation.
REQ-016 SHALL implement states IDLE, CLEAR, FEED, DRAIN and DONE with a 4-bit step counter t; all outputs registered.
REQ-017 IDLE: start=1 at an edge -> CLEAR in the next cycle (call it cycle 1); start=0 -> remain in IDLE.
REQ-018 CLEAR (cycle 1): pe_clear=1, a_edge=b_edge=0, busy=1, t reset to 0; next state FEED.
REQ-019 FEED (cycles 2..8, t=0..6): a_edge slice i = A[i][t-i] if 0<=t-i<=3, else 0; b_edge slice j = B[t-j][j] if 0<=t-j<=3, else 0; pe_clear=0.
REQ-020 FEED -> DRAIN after t=6; DRAIN (cycles 9..11, t=7..9) SHALL drive both edges to 0.
REQ-021 DRAIN -> DONE after t=9; DONE (cycle 12): done=1, busy=1, edges 0; next state IDLE with busy=0.
REQ-022 Total latency SHALL be 12 cycles from start acceptance to done; PE(3,3) receives its last product in cycle 11.
REQ-023 start SHALL be ignored in every state except IDLE; a start held high through DONE SHALL launch a new operation from IDLE on the following edge.
REQ-024 Skew SHALL place the signed operand bit pattern unchanged in each slice; zero-fill SHALL be all-zero bits.
REQ-025 Buffers SHALL persist across operations, so repeated start without rewrites recomputes the same C.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, t=0, busy=0, done=0, pe_clear=0, a_edge=b_edge=0, regardless of the clock.
REQ-027 rst_n=0 SHALL clear both buffers to 0.
REQ-028 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after release SHALL run a complete 12-cycle sequence.

Verification
REQ-029 A=identity, B[r][c]=r*4+c+1, start -> done in cycle 12; the attached array holds C=B; a_edge slice 0 = 1 in cycle 2 only.
REQ-030 All A=B=-128 -> each C element = 65536; b_edge slice 3 = 0x80 in cycles 5..8 and 0 in all other cycles.
REQ-031 start pulsed again in cycles 3 and 12 -> no effect on sequence; done occurs exactly once, in cycle 12.
REQ-032 wr_en writing A[0] = 5 during cycle 4 -> buffer unchanged; result matches the pre-start contents.
REQ-033 rst_n low in cycle 6 -> all outputs 0 immediately; no done; buffers read 0; a new start yields C=0 with done in cycle 12.
REQ-034 start held high continuously -> back-to-back operations with done pulses 13 cycles apart and pe_clear high in each CLEAR cycle.
